// File: rtl/divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | divider_pkg                                                                |
// | State encodings and counter sizing shared by the sequential divider.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package divider_pkg;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // Bits needed to hold n-1, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | divider_step                                                               |
// | One restoring-division iteration: shift in a dividend bit, trial-subtract. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_diff;
  logic             w_q;

  assign w_shift     = {i_rem, i_bit};
  assign w_borrow[0] = 1'b0;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_bits
      sub_cell u_cell (
        .i_a    (w_shift[g]),
        .i_b    (i_divisor[g]),
        .i_bin  (w_borrow[g]),
        .o_diff (w_diff[g]),
        .o_bout (w_borrow[g+1])
      );
    end
  endgenerate

  // MSB stage subtracts the divisor's implicit zero; only its borrow matters,
  // since any fitting trial result is below the divisor.
  assign w_q     = w_shift[WIDTH] | ~w_borrow[WIDTH];
  assign o_q_bit = w_q;
  assign o_rem   = w_q ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/sub_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sub_cell                                                                   |
// | One-bit full subtractor: a - b - borrow_in.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bout
);

  assign o_diff = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_divider                                                                |
// | Multi-cycle unsigned restoring divider, one quotient bit per clock.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_dsr_next;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dsr[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  assign w_dsr_next = {r_dsr[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_dvs       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_st_idle, c_st_done: begin
          r_state <= c_st_idle;
          if (start) begin
            if (divisor == '0) begin
              r_state     <= c_st_done;
              done        <= 1'b1;
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_state     <= c_st_calc;
              busy        <= 1'b1;
              r_dsr       <= dividend;
              r_dvs       <= divisor;
              r_rem       <= '0;
              r_cnt       <= CNT_W'(WIDTH - 1);
              div_by_zero <= 1'b0;
            end
          end
        end
        c_st_calc: begin
          r_rem <= w_rem_next;
          r_dsr <= w_dsr_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state   <= c_st_done;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= w_dsr_next;
            remainder <= w_rem_next;
          end
        end
        default: begin
          r_state <= c_st_idle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_divider                                                             |
// | Directed and swept checks of seq_divider at WIDTH=8 and WIDTH=16.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  dividend8 = '0, divisor8 = '0, quotient8, remainder8;
  logic        busy8, done8, dbz8;

  logic        start16 = 1'b0;
  logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;
  logic        busy16, done16, dbz16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dbz8)
  );

  seq_divider #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .dividend(dividend16), .divisor(divisor16),
    .busy(busy16), .done(done16), .quotient(quotient16), .remainder(remainder16),
    .div_by_zero(dbz16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Start a WIDTH=8 division; poke>0 re-pulses start with 50/5 at that cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input int poke);
    int cyc;
    dividend8 = a;
    divisor8  = b;
    start8    = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc    = 1;
    check("busy_first", busy8, (b != 0) ? 1 : 0);
    while (!done8 && cyc < 40) begin
      if (cyc == poke) begin
        start8    = 1'b1;
        dividend8 = 8'd50;
        divisor8  = 8'd5;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start8 = 1'b0;
    check("latency8", cyc, (b != 0) ? 9 : 1);
    check("quot8", quotient8, eq);
    check("rem8", remainder8, er);
    check("dbz8", dbz8, (b == 0) ? 1 : 0);
    check("busy_done8", busy8, 0);
    @(posedge clk); #1;
    check("done_pulse8", done8, 0);
    check("quot8_held", quotient8, eq);
  endtask

  realtime last_done = 0;
  bit      last_nz = 1'b0;

  // Returns in the DONE cycle, so back-to-back calls re-start from DONE.
  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    int cyc;
    logic [15:0] eq, er;
    eq = (b == 0) ? 16'd0 : a / b;
    er = (b == 0) ? a : a % b;
    dividend16 = a;
    divisor16  = b;
    start16    = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc     = 1;
    while (!done16 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency16", cyc, (b != 0) ? 17 : 1);
    check("quot16", quotient16, eq);
    check("rem16", remainder16, er);
    check("dbz16", dbz16, (b == 0) ? 1 : 0);
    if (last_nz && b != 0)
      check("period16", int'(($realtime - last_done) / 10.0), 17);
    last_done = $realtime;
    last_nz   = (b != 0);
  endtask

  initial begin
    int cyc;
    logic [15:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_quot", quotient8, 0);
    check("rst_rem", remainder8, 0);
    check("rst_dbz", dbz8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8(8'd200, 8'd7, 8'd28, 8'd4, 0);
    run8(8'd13, 8'd0, 8'd0, 8'd13, 0);
    check("busy0_after", busy8, 0);
    run8(8'd255, 8'd1, 8'd255, 8'd0, 0);
    run8(8'd5, 8'd9, 8'd0, 8'd5, 0);
    run8(8'd255, 8'd255, 8'd1, 8'd0, 0);
    run8(8'd100, 8'd3, 8'd33, 8'd1, 3);

    // Abort a division with reset part-way through CALC.
    dividend8 = 8'd100;
    divisor8  = 8'd3;
    start8    = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_quot", quotient8, 0);
    check("abort_rem", remainder8, 0);
    check("abort_dbz", dbz8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) cyc++;
    end
    check("abort_no_done", cyc, 0);
    run8(8'd9, 8'd2, 8'd4, 8'd1, 0);

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      case (i % 10)
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      run16(a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
